// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: run-time configurable serial pattern detector controller.
// Ports: clk/rst, cfg_* config write, start/abort, x_valid/x stream,
// match pulse, busy/done status, match_cnt readback.
module seq_det_ctrl #(
   parameter int PW = 8,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_we,
   input  logic [PW-1:0] cfg_pat,
   input  logic [4:0]    cfg_len,
   input  logic          cfg_ovl,
   input  logic [CW-1:0] cfg_tgt,
   input  logic          start,
   input  logic          abort,
   input  logic          x_valid,
   input  logic          x,
   output logic          match,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] match_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } st_t;

   st_t state;
   st_t state_nxt;

   logic [PW-1:0] pat;
   logic [PW-1:0] win;
   logic [PW-1:0] win_nxt;
   logic [PW-1:0] lmask;
   logic [4:0]    len;
   logic [4:0]    len_w;
   logic [4:0]    fill;
   logic [4:0]    fill_inc;
   logic          ovl;
   logic [CW-1:0] tgt;
   logic [CW-1:0] cnt_inc;

   logic acc;
   logic hit;
   logic mhit;
   logic reach;
   logic enter;
   logic cfg_ok;
   logic match_d;
   logic busy_d;
   logic done_d;

   // State, config, datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pat       <= '0;
         len       <= 5'd1;
         ovl       <= 1'b1;
         tgt       <= '0;
         win       <= '0;
         fill      <= '0;
         match_cnt <= '0;
         match     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state <= state_nxt;
         match <= match_d;
         busy  <= busy_d;
         done  <= done_d;
         if (cfg_ok) begin
            pat <= cfg_pat;
            len <= len_w;
            ovl <= cfg_ovl;
            tgt <= cfg_tgt;
         end
         if (enter) begin
            win       <= '0;
            fill      <= '0;
            match_cnt <= '0;
         end else if (acc && !abort) begin
            win <= win_nxt;
            // Non-overlap mode restarts the fill so the next match
            // needs a full set of fresh bits.
            fill <= (mhit && !ovl) ? 5'd0 : fill_inc;
            if (mhit) match_cnt <= cnt_inc;
         end
      end
   end

   // Next-state logic; abort has priority over start everywhere
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (!abort && start) state_nxt = RUN;
         RUN: begin
            if (abort)      state_nxt = IDLE;
            else if (reach) state_nxt = DONE;
         end
         DONE: begin
            if (abort)      state_nxt = IDLE;
            else if (start) state_nxt = RUN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath decode and registered-output next values
   always_comb begin
      cfg_ok = cfg_we && (state != RUN);
      len_w  = cfg_len;
      if (cfg_len == 5'd0)        len_w = 5'd1;
      else if (cfg_len > 5'(PW)) len_w = 5'(PW);

      acc      = (state == RUN) && x_valid;
      win_nxt  = {win[PW-2:0], x};
      fill_inc = (fill >= 5'(PW)) ? 5'(PW) : fill + 5'd1;

      lmask = '0;
      for (int i = 0; i < PW; i++) begin
         lmask[i] = (i < int'(len));
      end

      hit     = (((win_nxt ^ pat) & lmask) == '0) && (fill_inc >= len);
      mhit    = acc && hit && !abort;
      cnt_inc = (&match_cnt) ? match_cnt : match_cnt + 1'b1;
      reach   = mhit && (tgt != '0) && (cnt_inc == tgt);
      enter   = (state != RUN) && (state_nxt == RUN);

      match_d = mhit;
      busy_d  = (state_nxt == RUN);
      done_d  = (state_nxt == DONE);
   end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: directed self-checking bench for seq_det_ctrl.
// Drives config/run/stream steps and checks registered outputs.
module tb_seq_det_ctrl;

   localparam int PW = 8;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_we;
   logic [PW-1:0] cfg_pat;
   logic [4:0]    cfg_len;
   logic          cfg_ovl;
   logic [CW-1:0] cfg_tgt;
   logic          start;
   logic          abort;
   logic          x_valid;
   logic          x;
   logic          match;
   logic          busy;
   logic          done;
   logic [CW-1:0] match_cnt;

   int errs   = 0;
   int checks = 0;

   seq_det_ctrl #(.PW(PW), .CW(CW)) dut (
      .clk      (clk),
      .rst      (rst),
      .cfg_we   (cfg_we),
      .cfg_pat  (cfg_pat),
      .cfg_len  (cfg_len),
      .cfg_ovl  (cfg_ovl),
      .cfg_tgt  (cfg_tgt),
      .start    (start),
      .abort    (abort),
      .x_valid  (x_valid),
      .x        (x),
      .match    (match),
      .busy     (busy),
      .done     (done),
      .match_cnt(match_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cfg(input logic [PW-1:0] p, input logic [4:0] l,
                      input logic o, input logic [CW-1:0] t);
      cfg_pat = p;
      cfg_len = l;
      cfg_ovl = o;
      cfg_tgt = t;
      cfg_we  = 1'b1;
      tick();
      cfg_we  = 1'b0;
   endtask

   task automatic go(input string tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_cnt0"}, 32'(match_cnt), 32'd0);
   endtask

   task automatic bit_in(input string tag, input logic b, input logic v,
                         input logic em);
      x       = b;
      x_valid = v;
      tick();
      x_valid = 1'b0;
      chk(tag, 32'(match), 32'(em));
   endtask

   task automatic stop();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   logic [7:0] s1;
   logic [7:0] e1;
   logic [7:0] e2;

   initial begin
      rst = 1'b1; cfg_we = 0; cfg_pat = '0; cfg_len = '0; cfg_ovl = 0;
      cfg_tgt = '0; start = 0; abort = 0; x_valid = 0; x = 0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_match", 32'(match), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_cnt", 32'(match_cnt), 32'd0);

      // Overlapping run: stream 1,0,1,1,0,1,1,0
      s1 = 8'b1011_0110;
      e1 = 8'b0000_1001;
      e2 = 8'b0000_1000;
      cfg(8'b10110, 5'd5, 1'b1, 8'd0);
      go("ovl");
      for (int i = 0; i < 8; i++) bit_in("ovl_m", s1[7-i], 1'b1, e1[7-i]);
      chk("ovl_cnt", 32'(match_cnt), 32'd2);
      chk("ovl_busy", 32'(busy), 32'd1);
      stop();
      chk("ovl_ab_busy", 32'(busy), 32'd0);
      chk("ovl_ab_cnt", 32'(match_cnt), 32'd2);

      // Non-overlapping run
      cfg(8'b10110, 5'd5, 1'b0, 8'd0);
      go("nov");
      for (int i = 0; i < 8; i++) bit_in("nov_m", s1[7-i], 1'b1, e2[7-i]);
      chk("nov_cnt", 32'(match_cnt), 32'd1);
      stop();

      // Target stop: pat 11 len 2 tgt 2
      cfg(8'b11, 5'd2, 1'b1, 8'd2);
      go("tgt");
      bit_in("tgt_b1", 1'b1, 1'b1, 1'b0);
      bit_in("tgt_b2", 1'b1, 1'b1, 1'b1);
      chk("tgt_busy2", 32'(busy), 32'd1);
      bit_in("tgt_b3", 1'b1, 1'b1, 1'b1);
      chk("tgt_done", 32'(done), 32'd1);
      chk("tgt_busy", 32'(busy), 32'd0);
      chk("tgt_cnt", 32'(match_cnt), 32'd2);
      bit_in("tgt_b4", 1'b1, 1'b1, 1'b0);
      chk("tgt_cnt4", 32'(match_cnt), 32'd2);
      stop();
      chk("tgt_ab_done", 32'(done), 32'd0);

      // Gaps and config lock
      cfg(8'b10110, 5'd5, 1'b1, 8'd0);
      go("gap");
      bit_in("gap_1", 1'b1, 1'b1, 1'b0);
      bit_in("gap_g1", 1'b1, 1'b0, 1'b0);
      bit_in("gap_2", 1'b0, 1'b1, 1'b0);
      cfg_pat = '0;
      cfg_we  = 1'b1;
      bit_in("gap_g2", 1'b1, 1'b0, 1'b0);
      cfg_we  = 1'b0;
      bit_in("gap_3", 1'b1, 1'b1, 1'b0);
      bit_in("gap_4", 1'b1, 1'b1, 1'b0);
      bit_in("gap_g3", 1'b0, 1'b0, 1'b0);
      bit_in("gap_5", 1'b0, 1'b1, 1'b1);
      chk("gap_cnt", 32'(match_cnt), 32'd1);

      // start and abort together mid-run
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("pri_busy", 32'(busy), 32'd0);
      chk("pri_done", 32'(done), 32'd0);
      chk("pri_cnt", 32'(match_cnt), 32'd1);

      // Abort on the completing bit discards the match
      go("abm");
      bit_in("abm_1", 1'b1, 1'b1, 1'b0);
      bit_in("abm_2", 1'b0, 1'b1, 1'b0);
      bit_in("abm_3", 1'b1, 1'b1, 1'b0);
      bit_in("abm_4", 1'b1, 1'b1, 1'b0);
      abort = 1'b1;
      bit_in("abm_5", 1'b0, 1'b1, 1'b0);
      abort = 1'b0;
      chk("abm_cnt", 32'(match_cnt), 32'd0);
      chk("abm_busy", 32'(busy), 32'd0);

      // len 0 clamps to 1
      cfg(8'h01, 5'd0, 1'b1, 8'd0);
      go("cl0");
      bit_in("cl0_1", 1'b1, 1'b1, 1'b1);
      bit_in("cl0_2", 1'b0, 1'b1, 1'b0);
      bit_in("cl0_3", 1'b1, 1'b1, 1'b1);
      chk("cl0_cnt", 32'(match_cnt), 32'd2);
      stop();

      // len 20 clamps to PW
      cfg(8'hFF, 5'd20, 1'b1, 8'd0);
      go("clh");
      for (int i = 0; i < 9; i++) bit_in("clh_m", 1'b1, 1'b1, i >= 7);
      chk("clh_cnt", 32'(match_cnt), 32'd2);

      // Reset mid-run restores outputs and config
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_done", 32'(done), 32'd0);
      chk("mr_match", 32'(match), 32'd0);
      chk("mr_cnt", 32'(match_cnt), 32'd0);
      bit_in("mr_idle", 1'b0, 1'b1, 1'b0);
      go("mr");
      bit_in("mr_p0", 1'b0, 1'b1, 1'b1);
      bit_in("mr_p1", 1'b1, 1'b1, 1'b0);
      chk("mr_cnt1", 32'(match_cnt), 32'd1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Controller that configures and sequences a programmable serial pattern detector: it holds a loadable pattern, length, overlap mode and match target, arms detection on `start`, scans a qualified serial bit stream and counts matches. It stops itself when the target count is reached. It sits between the host/config side and the serial front end, replacing fixed-pattern detectors with one run-time configurable block.

## Interface
- `PW`, 8: maximum pattern width in bits (2..16).
- `CW`, 8: match counter / target width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_we`  in  1  config write strobe; accepted only in IDLE or DONE.
- `cfg_pat`  in  PW  pattern; bit `[len-1]` is the first bit received, bit `[0]` the last.
- `cfg_len`  in  5  pattern length.
- `cfg_ovl`  in  1  1 = overlapping matches allowed, 0 = non-overlapping.
- `cfg_tgt`  in  CW  number of matches after which the run ends; 0 = run until abort.
- `start`  in  1  begin a run, from IDLE or DONE.
- `abort`  in  1  end the run immediately.
- `x_valid`  in  1  qualifies `x`.
- `x`  in  1  serial data bit.
- `match`  out  1  one-cycle pulse per detected match.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `match_cnt`  out  CW  matches in the current or last run.

## Operation
- Config registers reset to: `pat`=0, `len`=1, `ovl`=1, `tgt`=0.
- `cfg_we` in RUN is ignored; registers keep their values.
- `len` is clamped at write time: 0 stored as 1, values above PW stored as PW.
- Internal datapath:
  - window shift register (PW bits);
  - fill counter (0..PW, saturating);
  - match counter (CW bits, saturating at all-ones).
- Accepted bit = RUN && `x_valid`:
  - window <= {window[PW-2:0], x};
  - fill <= min(fill+1, PW).
- Match condition on an accepted bit: (new window)[len-1:0] == `pat`[len-1:0] and new fill >= len.
- On a match:
  - `match` pulses;
  - `match_cnt` increments;
  - if `ovl`=0, fill is cleared to 0 in the same update, so the next match needs len fresh bits.
- FSM states: IDLE (reset), RUN, DONE.
  - IDLE: `start` -> RUN.
  - RUN: `abort` -> IDLE. A match that brings `match_cnt` to `tgt` (`tgt`≠0) -> DONE. Otherwise stay in RUN.
  - DONE: `start` -> RUN. `abort` -> IDLE.
- Entering RUN clears window, fill and `match_cnt`.
- Leaving RUN by abort keeps `match_cnt` for readback.
- Bits with `x_valid`=0, and all bits outside RUN, have no effect.
- Simultaneous events:
  - `abort` beats `start`.
  - `start` in RUN is ignored.
  - An accepted matching bit in the same cycle as `abort` is discarded: no pulse, no count.
- Reset values: `match`=0, `busy`=0, `done`=0, `match_cnt`=0, state IDLE.

## Timing
- All outputs are registered.
- Latency:
  - final pattern bit accepted in cycle t -> `match` high in cycle t+1 only;
  - `match_cnt` shows the new value in t+1.
- Target reached by the match accepted in cycle t -> `busy`=0 and `done`=1 from t+1. Further bits are ignored from t+1.
- `start` sampled in cycle t -> `busy`=1 from t+1. The first bit can be accepted in t+1.
- `abort` sampled in cycle t -> IDLE and `busy`=0 from t+1.
- Back-to-back matches on consecutive accepted bits are possible with `ovl`=1 (e.g. pattern 11, len 2). `match` is then high on consecutive cycles.
- `rst` mid-run returns everything to reset values, including the config registers, on the next edge.

## Test plan
- Overlapping run:
  - config pat=0b10110, len=5, ovl=1, tgt=0; start; stream 1,0,1,1,0,1,1,0 with `x_valid`=1;
  - `match` pulses the cycle after bit 5 and after bit 8; `match_cnt`=2; `busy` stays 1.
- Non-overlapping run:
  - same config and stream, but ovl=0;
  - single pulse after bit 5; `match_cnt`=1.
- Target stop:
  - pat=0b11, len=2, ovl=1, tgt=2; stream 1,1,1,1;
  - pulses after bits 2 and 3; `done`=1 and `busy`=0 from the cycle after bit 3; bit 4 does not pulse; `match_cnt` stays 2.
- Gaps and config lock:
  - run with pat=0b10110, len=5, ovl=1, tgt=0; insert `x_valid`=0 cycles between pattern bits;
  - the match still occurs exactly one cycle after the 5th valid bit;
  - a `cfg_we` with pat=0 during RUN leaves detection of 10110 unchanged.
- Abort and priority:
  - mid-run, assert `start` and `abort` together → IDLE next cycle, `match_cnt` retained;
  - abort on the cycle of a completing bit → no `match` pulse.
- Reset and clamp:
  - `cfg_len`=0 acts as len 1 (pat bit0=1 matches every accepted 1);
  - `rst` mid-run → all outputs 0, state IDLE, config back to reset values.
